// File: rtl/des_result_checker.sv
// Result checker for the DES bench: queues expected words in a FIFO, compares them
// in order against the core's output stream and produces a registered pass/fail verdict.
module des_result_checker #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_vec,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              dut_valid,
    input  logic [DATA_W-1:0] dut_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [15:0]       chk_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_idx,
    output logic              orphan,
    output logic              timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic [15:0]       num_lat;
    logic [IW-1:0]     idle_cnt;

    logic        in_run, push, pop, is_orphan, mismatch, new_err;
    logic        timeout_hit, verdict, orphan_next;
    logic [15:0] chk_next, err_next;

    assign in_run    = (state == RUN);
    assign push      = exp_valid & exp_ready;
    assign pop       = in_run & dut_valid & (count != '0);
    assign is_orphan = in_run & dut_valid & (count == '0);
    assign mismatch  = pop & (mem[rd_ptr] != dut_data);
    assign new_err   = mismatch | is_orphan;

    // Next-state and next counter values; the verdict is formed from the values
    // that will be registered on the edge that enters DONE.
    always_comb begin
        state_next  = state;
        chk_next    = chk_cnt;
        err_next    = err_cnt;
        orphan_next = orphan;
        timeout_hit = 1'b0;
        count_next  = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
        if (in_run && dut_valid) begin
            chk_next = (chk_cnt == 16'hFFFF) ? chk_cnt : chk_cnt + 16'd1;
            if (new_err)
                err_next = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            if (is_orphan)
                orphan_next = 1'b1;
        end
        if (start) begin
            state_next = RUN;
        end else if (in_run) begin
            if (chk_next >= num_lat) begin
                state_next = DONE;
            end else if (!dut_valid && idle_cnt == IW'(TIMEOUT - 1)) begin
                state_next  = DONE;
                timeout_hit = 1'b1;
            end
        end
        verdict = (err_next == 16'd0) && !orphan_next && !timeout_hit && (count_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            exp_ready     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            chk_cnt       <= 16'd0;
            err_cnt       <= 16'd0;
            first_err_idx <= 16'hFFFF;
            orphan        <= 1'b0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            idle_cnt      <= '0;
            num_lat       <= 16'd0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == RUN);
            done      <= (state_next == DONE);
            exp_ready <= (state_next == RUN) && (start || count_next != CW'(FIFO_DEPTH));
            if (start) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                count         <= '0;
                chk_cnt       <= 16'd0;
                err_cnt       <= 16'd0;
                first_err_idx <= 16'hFFFF;
                orphan        <= 1'b0;
                timeout       <= 1'b0;
                pass          <= 1'b0;
                fail          <= 1'b0;
                idle_cnt      <= '0;
                num_lat       <= num_vec;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count   <= count_next;
                chk_cnt <= chk_next;
                err_cnt <= err_next;
                orphan  <= orphan_next;
                // err_cnt only ever leaves zero once, so it marks the first error
                if (new_err && err_cnt == 16'd0)
                    first_err_idx <= chk_cnt;
                if (in_run)
                    idle_cnt <= dut_valid ? '0 : idle_cnt + IW'(1);
                if (timeout_hit)
                    timeout <= 1'b1;
                if (in_run && state_next == DONE) begin
                    pass <= verdict;
                    fail <= !verdict;
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !start)
            mem[wr_ptr] <= exp_data;
    end

endmodule

// File: doc/des_result_checker.md
# des_result_checker

Self-checking result stage for the DES testbench, placed directly downstream of the DES core and upstream of the pass/fail banner tasks. It buffers expected ciphertext/plaintext words in a small FIFO and compares them in order against the core's output stream. It counts checks and mismatches, detects missing and unexpected results, and raises a final registered `pass`/`fail` verdict with `done`. The bench waits on `done` and calls `show_pass` or `show_fail` accordingly.

## Interface
Parameters:
- `DATA_W`, 64: width of the expected and DUT result words.
- `FIFO_DEPTH`, 16: expected-word FIFO depth; must be a power of 2, ≥ 2.
- `TIMEOUT`, 1024: idle cycles allowed in RUN without `dut_valid` before aborting.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; clears all state and begins a run.
- `num_vec` in 16: number of results expected; sampled on `start`.
- `exp_valid` in 1, `exp_data` in DATA_W, `exp_ready` out 1: expected-word push handshake. A word transfers when `exp_valid & exp_ready`.
- `dut_valid` in 1, `dut_data` in DATA_W: DES core output. No backpressure is applied to this stream.
- `busy` out 1: in RUN.
- `done` out 1: level, in DONE.
- `pass` out 1, `fail` out 1: verdict; meaningful only while `done`=1.
- `chk_cnt` out 16: number of results checked.
- `err_cnt` out 16: number of mismatches plus orphans.
- `first_err_idx` out 16: `chk_cnt` value of the first error; 0xFFFF if there is none.
- `orphan` out 1: sticky; a result arrived while the FIFO was empty.
- `timeout` out 1: sticky; the run ended by timeout.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `chk_cnt` reaches the latched `num_vec`, or when the idle counter reaches `TIMEOUT`.
  - DONE → RUN on `start`.
  - `start` in RUN aborts the current run and restarts it. The FIFO is flushed and counters are cleared in the same cycle.
- `start` with `num_vec`=0: go to RUN, then DONE on the next cycle with `pass`=1.
- `exp_ready` = (state==RUN) & !fifo_full. Pushes outside RUN are not accepted.
- On `dut_valid` in RUN:
  - FIFO non-empty: pop the head and compare it with `dut_data`. Increment `err_cnt` if they differ.
  - FIFO empty: increment `err_cnt` and set `orphan`. Nothing is popped.
  - Increment `chk_cnt` in either case.
  - If this is the first error, set `first_err_idx` to the pre-increment `chk_cnt`.
- The comparison sees only words already stored in the FIFO. A push and a `dut_valid` in the same cycle with the FIFO empty is an orphan; there is no bypass. Simultaneous push and pop on a non-empty FIFO is legal and leaves the occupancy unchanged.
- `dut_valid` in IDLE or DONE is ignored.
- Idle counter: cleared on `start` and on every `dut_valid`; increments each RUN cycle otherwise.
- Verdict on entry to DONE: `pass` = (err_cnt==0) & !orphan & !timeout & fifo_empty. `fail` = !pass. Words left in the FIFO are a failure.
- `chk_cnt` and `err_cnt` saturate at 0xFFFF.
- Reset values:
  - state IDLE.
  - FIFO empty.
  - `busy`, `done`, `pass`, `fail`, `orphan`, `timeout`, `exp_ready` = 0.
  - `chk_cnt` = `err_cnt` = 0.
  - `first_err_idx` = 0xFFFF.
- `rst` mid-run returns to IDLE immediately, losing all state. `start` clears the same state synchronously.

## Timing
- All outputs are registered.
- `dut_valid` at edge n: `chk_cnt`, `err_cnt`, and the flags update at n+1.
- Last check at edge n: `done`, `pass`, and `fail` are valid at n+1. `busy` falls in that same cycle.
- FIFO: a push at edge n is poppable from edge n+1.
- `exp_ready` deasserts in the cycle after the push that fills the FIFO.
- Timeout: `TIMEOUT` consecutive RUN cycles without `dut_valid` → DONE on the next edge with `timeout`=1.
- `start` at edge n: `busy`=1 and all counters are 0 from n+1.

## Test plan
- All match: `num_vec`=3. Push 0x85E813540F0AB405, 0x0123456789ABCDEF, and 0x1 into the FIFO. Drive the same three words on `dut_valid`. Expect `done`=1 one cycle after the 3rd result, `pass`=1, `chk_cnt`=3, `err_cnt`=0, `first_err_idx`=0xFFFF.
- Mismatch: same as above, but the 2nd DUT word has bit 0 flipped. Expect `fail`=1, `err_cnt`=1, `first_err_idx`=1.
- Orphan: `num_vec`=2, one expected word pushed, two DUT results. Expect `orphan`=1, `err_cnt`=1, `fail`=1. Separately, a push and a result in the same cycle on an empty FIFO → also orphan.
- Timeout and leftover words:
  - `TIMEOUT`=8, `num_vec`=2, one result only. Expect DONE 8 cycles after that result with `timeout`=1 and `fail`=1.
  - `num_vec`=1 with 2 words pushed → `fail` because the FIFO is non-empty.
- FIFO full: push `FIFO_DEPTH`+2 words with `exp_valid` held high. Expect `exp_ready`=0 after the FIFO fills. Then one `dut_valid` pop re-enables `exp_ready`, and no words are lost (verified by subsequent matches).
- Abort: `start` mid-run, then `rst` mid-run. Expect counters at 0 and FIFO empty after `start`. Expect IDLE with all reset values immediately after `rst` asserts, independent of `clk`.
